sort_job_ctrl: RTL and testbench
================================

Name: sort_job_ctrl

Overview:
- Job controller for the pipelined odd-even transposition sorter (fixed-latency, non-stallable, N stages of K-bit lanes).
- Accepts unsorted vectors on a valid/ready slave port and issues them into the sorter. Tracks in-flight jobs with a tag shift register, captures results into a local result FIFO and presents them on a valid/ready master port.
- Credit-based admission guarantees no result is lost, because the sorter cannot be back-pressured. A drain/halt FSM gives software a clean quiesce point.

Parameters:
N, 8, lanes per vector
K, 8, bits per lane
SORT_LAT, 9, sorter latency in cycles from srt_in sampled to srt_out valid (input register + N stages); must be >= 1
OUT_DEPTH, 16, result FIFO depth; must be >= 1; full throughput requires OUT_DEPTH >= SORT_LAT+2
TAG_W, 4, job tag width carried alongside data
CNT_W, 16, completed-job counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_valid  in  1  job request valid
s_ready  out  1  controller can accept job
s_data  in  N*K  unsorted vector
s_tag  in  TAG_W  job tag
srt_in  out  N*K  vector to sorter input
srt_out  in  N*K  vector from sorter output
m_valid  out  1  sorted result valid
m_ready  in  1  downstream accepts result
m_data  out  N*K  sorted vector (FIFO head)
m_tag  out  TAG_W  tag of m_data
drain_req  in  1  stop admission and empty the pipe (level or pulse)
resume  in  1  leave HALT (pulse)
halted  out  1  high in HALT state
busy  out  1  inflight != 0 or FIFO non-empty
jobs_done  out  CNT_W  count of results popped on m port, wraps

Behaviour:
- Reset (sync, rst=1 at posedge): FSM=RUN; inflight=0; fifo_count=0; valid/tag shift register cleared; jobs_done=0. Outputs: s_ready=1, m_valid=0, halted=0, busy=0, m_data/m_tag=0.
- accept = s_valid & s_ready. srt_in = accept ? s_data : 0 (combinational). The sorter samples it on the same edge.
- Tracker: vld_sr[0..SORT_LAT-1] and tag_sr[0..SORT_LAT-1] shift every cycle. A job accepted at edge t retires (retire=1) at edge t+SORT_LAT. On that edge srt_out and the matching tag are written to the FIFO.
- Counters (registered): inflight += accept - retire; fifo_count += retire - pop, where pop = m_valid & m_ready.
- Admission: s_ready = (state==RUN) & (inflight + fifo_count < OUT_DEPTH), using registered values only.
  - A pop in the same cycle does not free a credit until the next cycle (conservative, no comb path m_ready->s_ready).
- Invariant: inflight + fifo_count <= OUT_DEPTH. A retire into a full FIFO is impossible; the bench asserts this.
- Latency: s accept at edge t -> m_valid high in cycle after edge t+SORT_LAT (empty FIFO); i.e. SORT_LAT+1 cycles.
- Ordering: strict FIFO; results leave in acceptance order with their tags.
- m side: m_valid = FIFO non-empty. m_data/m_tag are held stable while m_valid & !m_ready. A full FIFO with m_ready=0 stalls admission only, never the sorter.
- Simultaneous retire and pop with the FIFO full or empty: both take effect. An empty FIFO with retire+pop is impossible, since m_valid=0.
- FSM:
  - RUN -> DRAIN when drain_req=1.
  - DRAIN: s_ready=0. Results continue to retire and pop.
  - DRAIN -> HALT when inflight==0 & fifo_count==0.
  - HALT: halted=1, s_ready=0. HALT -> RUN on resume=1.
  - drain_req has priority over resume in HALT (stay).
  - resume is ignored in RUN/DRAIN. drain_req is ignored in DRAIN/HALT.
- jobs_done increments on each pop and wraps 2^CNT_W-1 -> 0.
- Reset mid-operation: all in-flight jobs and FIFO contents are discarded. Stale sorter contents are ignored because vld_sr is cleared; no spurious m_valid after reset.

Decomposition:
- Package sort_pkg: FSM enum (RUN, DRAIN, HALT), default N/K/TAG_W, SORT_LAT function of N (N+1).
- Sub-module sort_res_fifo: synchronous FIFO, width N*K+TAG_W, depth OUT_DEPTH, with count output, same clk/rst.
- Tracker, counters, FSM and admission logic stay in sort_job_ctrl.

Test Plan:
- Single job: s_data lanes {7,3,0,5,1,6,2,4}, tag 3, m_ready=1 -> m_valid exactly SORT_LAT+1 cycles after accept, m_data sorted per sorter order, m_tag=3, jobs_done=1.
- Back-to-back: 100 jobs every cycle, m_ready=1, OUT_DEPTH=16 -> s_ready never drops after reset, 100 results in order, tags 0..15 cycling, jobs_done=100.
- Backpressure: m_ready=0, s_valid=1 continuously -> exactly OUT_DEPTH=16 accepts, then s_ready=0. Raising m_ready delivers all 16 in order with no loss.
- Drain: 5 jobs in flight, drain_req pulse -> s_ready=0 next cycle, 5 results delivered, halted=1 once busy=0. resume pulse -> s_ready=1.
- Reset mid-flight: 4 jobs accepted, rst asserted one cycle -> m_valid stays 0 for 2*SORT_LAT cycles, busy=0, jobs_done=0.
- OUT_DEPTH=1 config: continuous s_valid, m_ready=1 -> one job per SORT_LAT+2 cycles, no FIFO overflow assertion.

Source files
------------

// File: rtl/sort_job_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sort_pkg
//   Shared types and defaults for the sorter job controller slice.
//   - ctrl_state_e : admission/quiesce FSM states
//   - DEF_*        : default geometry of the odd-even transposition sorter
//   - sort_lat()   : sorter latency as a function of lane count (input
//                    register plus one compare-exchange stage per lane)
//   - occ_bits()   : width needed to hold a count in the range 0..max_val
// ---------------------------------------------------------------------------
package sort_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } ctrl_state_e;

  localparam int DEF_N     = 8;
  localparam int DEF_K     = 8;
  localparam int DEF_TAG_W = 4;

  function automatic int sort_lat(input int n);
    return n + 1;
  endfunction

  localparam int DEF_SORT_LAT = sort_lat(DEF_N);

  function automatic int occ_bits(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sort_job_ctrl_res_fifo.sv
// ---------------------------------------------------------------------------
// sort_res_fifo
//   Synchronous result FIFO (first-word fall-through). The head entry is
//   visible on rd_data whenever count != 0 and reads as zero when empty, so
//   the master port shows zero data while idle.
//
// Ports
//   clk, rst  : clock, synchronous active-high reset (pointers/count only;
//               storage is not reset because it is never read while empty)
//   wr_en     : push wr_data (caller guarantees the FIFO is not full)
//   wr_data   : entry to push
//   rd_en     : pop the head entry (ignored when empty)
//   rd_data   : head entry, zero when empty
//   count     : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sort_res_fifo
  import sort_pkg::*;
#(
  parameter int WIDTH    = 72,
  parameter int DEPTH    = 16,
  parameter int CNT_BITS = occ_bits(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                rd_en,
  output logic [WIDTH-1:0]    rd_data,
  output logic [CNT_BITS-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_BITS-1:0] cnt;
  logic                not_empty;
  logic                rd_ok;

  // Pointer advance with explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign not_empty = (cnt != '0);
  assign rd_ok     = rd_en & not_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      cnt <= cnt + CNT_BITS'(wr_en) - CNT_BITS'(rd_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = not_empty ? mem[rd_ptr] : '0;
  assign count   = cnt;

endmodule

// File: rtl/sort_job_ctrl.sv
// ---------------------------------------------------------------------------
// sort_job_ctrl
//   Job controller wrapped around a fixed-latency, non-stallable pipelined
//   sorter. Jobs enter on a valid/ready slave port and are launched straight
//   into the sorter; a valid/tag shift register follows each job down the
//   pipe so its result can be captured into a local FIFO exactly SORT_LAT
//   edges later. Because the sorter cannot be stalled, a job is admitted
//   only if a FIFO slot is already reserved for it (credit = in-flight jobs
//   plus stored results must stay below OUT_DEPTH). A RUN/DRAIN/HALT FSM
//   lets software stop admission and wait for the pipe and FIFO to empty.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   s_valid/s_ready     : job handshake; s_data unsorted vector, s_tag tag
//   srt_in              : vector to sorter (zero unless a job is accepted)
//   srt_out             : sorter output, valid SORT_LAT edges after launch
//   m_valid/m_ready     : result handshake; m_data sorted vector, m_tag tag
//   drain_req           : stop admission and empty the pipe (level or pulse)
//   resume              : leave HALT (pulse)
//   halted              : high while in HALT
//   busy                : jobs in flight or results still stored
//   jobs_done           : results popped on the master port, wraps
// ---------------------------------------------------------------------------
module sort_job_ctrl
  import sort_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int K         = DEF_K,
  parameter int SORT_LAT  = sort_lat(N),
  parameter int OUT_DEPTH = 16,
  parameter int TAG_W     = DEF_TAG_W,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [N*K-1:0]     s_data,
  input  logic [TAG_W-1:0]   s_tag,
  output logic [N*K-1:0]     srt_in,
  input  logic [N*K-1:0]     srt_out,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [N*K-1:0]     m_data,
  output logic [TAG_W-1:0]   m_tag,
  input  logic               drain_req,
  input  logic               resume,
  output logic               halted,
  output logic               busy,
  output logic [CNT_W-1:0]   jobs_done
);

  localparam int VEC_W  = N * K;
  localparam int FIFO_W = VEC_W + TAG_W;
  localparam int FCNT_W = occ_bits(OUT_DEPTH);
  // One spare bit so inflight + fifo_count can never wrap in the compare.
  localparam int OCC_W  = occ_bits(OUT_DEPTH + SORT_LAT) + 1;

  ctrl_state_e         state;
  ctrl_state_e         state_nxt;

  logic                accept;
  logic                retire;
  logic                pop;
  logic                credit_ok;
  logic                pipe_empty;

  logic [SORT_LAT-1:0] vld_sr;
  logic [TAG_W-1:0]    tag_sr [SORT_LAT];

  logic [OCC_W-1:0]    inflight;
  logic [FCNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]    jobs_cnt;

  logic [FIFO_W-1:0]   fifo_wr_data;
  logic [FIFO_W-1:0]   fifo_rd_data;

  // -------------------------------------------------------------------------
  // Admission: credits come from registered counters only, so a pop in this
  // cycle frees its slot one cycle later and m_ready never reaches s_ready.
  // -------------------------------------------------------------------------
  assign credit_ok = (inflight + OCC_W'(fifo_count)) < OCC_W'(OUT_DEPTH);
  assign s_ready   = (state == ST_RUN) & credit_ok;
  assign accept    = s_valid & s_ready;
  assign srt_in    = accept ? s_data : '0;

  // -------------------------------------------------------------------------
  // Tracker: slot 0 is loaded on the launch edge alongside the sorter input
  // register; the last slot lines up with srt_out, so its valid bit is the
  // retire strobe for the FIFO write.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
      for (int i = 0; i < SORT_LAT; i++) begin
        tag_sr[i] <= '0;
      end
    end else begin
      vld_sr[0] <= accept;
      tag_sr[0] <= s_tag;
      for (int i = 1; i < SORT_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

  assign retire = vld_sr[SORT_LAT-1];

  // -------------------------------------------------------------------------
  // Capture: sorter result and its tag enter the result FIFO on retire.
  // -------------------------------------------------------------------------
  assign fifo_wr_data = {srt_out, tag_sr[SORT_LAT-1]};

  sort_res_fifo #(
    .WIDTH    (FIFO_W),
    .DEPTH    (OUT_DEPTH),
    .CNT_BITS (FCNT_W)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (retire),
    .wr_data (fifo_wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count)
  );

  assign m_valid = (fifo_count != '0);
  assign pop     = m_valid & m_ready;
  assign m_data  = fifo_rd_data[FIFO_W-1:TAG_W];
  assign m_tag   = fifo_rd_data[TAG_W-1:0];

  // -------------------------------------------------------------------------
  // Occupancy and completion counters.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
      jobs_cnt <= '0;
    end else begin
      inflight <= inflight + OCC_W'(accept) - OCC_W'(retire);
      jobs_cnt <= jobs_cnt + CNT_W'(pop);
    end
  end

  assign pipe_empty = (inflight == '0) & (fifo_count == '0);
  assign busy       = ~pipe_empty;
  assign jobs_done  = jobs_cnt;

  // -------------------------------------------------------------------------
  // Quiesce FSM.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    halted    = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (drain_req) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pipe_empty) begin
          state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        // A still-asserted drain request holds the block quiesced.
        if (resume && !drain_req) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_sort_job_ctrl.sv
module tb_sort_job_ctrl;

  localparam int N         = 8;
  localparam int K         = 8;
  localparam int SORT_LAT  = 9;
  localparam int OUT_DEPTH = 16;
  localparam int TAG_W     = 4;
  localparam int CNT_W     = 16;
  localparam int CNT_W1    = 4;

  typedef struct packed {
    logic [N*K-1:0]   d;
    logic [TAG_W-1:0] t;
  } item_t;

  logic clk = 1'b0;
  logic rst;

  // main instance (OUT_DEPTH = 16)
  logic               s_valid, s_ready, m_valid, m_ready;
  logic [N*K-1:0]     s_data, srt_in, srt_out, m_data;
  logic [TAG_W-1:0]   s_tag, m_tag;
  logic               drain_req, resume, halted, busy;
  logic [CNT_W-1:0]   jobs_done;

  // second instance (OUT_DEPTH = 1, narrow counter)
  logic               s_valid1, s_ready1, m_valid1, m_ready1;
  logic [N*K-1:0]     s_data1, srt_in1, srt_out1, m_data1;
  logic [TAG_W-1:0]   s_tag1, m_tag1;
  logic               drain_req1, resume1, halted1, busy1;
  logic [CNT_W1-1:0]  jobs_done1;

  int checks   = 0;
  int failures = 0;

  item_t acc_q[$];
  item_t got_q[$];
  int    occ0, occ1;

  always #5 clk = ~clk;

  sort_job_ctrl #(.N(N), .K(K), .SORT_LAT(SORT_LAT), .OUT_DEPTH(OUT_DEPTH),
                  .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_tag(s_tag), .srt_in(srt_in), .srt_out(srt_out), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_tag(m_tag), .drain_req(drain_req),
    .resume(resume), .halted(halted), .busy(busy), .jobs_done(jobs_done));

  sort_job_ctrl #(.N(N), .K(K), .SORT_LAT(SORT_LAT), .OUT_DEPTH(1),
                  .TAG_W(TAG_W), .CNT_W(CNT_W1)) dut1 (
    .clk(clk), .rst(rst), .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
    .s_tag(s_tag1), .srt_in(srt_in1), .srt_out(srt_out1), .m_valid(m_valid1),
    .m_ready(m_ready1), .m_data(m_data1), .m_tag(m_tag1), .drain_req(drain_req1),
    .resume(resume1), .halted(halted1), .busy(busy1), .jobs_done(jobs_done1));

  // Ascending sort, lane 0 receives the smallest value.
  function automatic logic [N*K-1:0] sort_vec(input logic [N*K-1:0] v);
    logic [K-1:0] a [N];
    logic [K-1:0] t;
    logic [N*K-1:0] r;
    for (int i = 0; i < N; i++) a[i] = v[i*K +: K];
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    for (int i = 0; i < N; i++) r[i*K +: K] = a[i];
    return r;
  endfunction

  function automatic logic [N*K-1:0] rand_vec();
    logic [N*K-1:0] v;
    for (int i = 0; i < N; i++) v[i*K +: K] = K'($urandom);
    return v;
  endfunction

  // Sorter models: SORT_LAT register stages, result visible SORT_LAT edges
  // after the edge that samples srt_in.
  logic [N*K-1:0] pipe0 [SORT_LAT];
  logic [N*K-1:0] pipe1 [SORT_LAT];
  always @(posedge clk) begin
    pipe0[0] <= sort_vec(srt_in);
    pipe1[0] <= sort_vec(srt_in1);
    for (int i = 1; i < SORT_LAT; i++) begin
      pipe0[i] <= pipe0[i-1];
      pipe1[i] <= pipe1[i-1];
    end
  end
  assign srt_out  = pipe0[SORT_LAT-1];
  assign srt_out1 = pipe1[SORT_LAT-1];

  // Handshake monitor and credit invariant (accepted but not yet popped).
  always @(negedge clk) begin
    if (rst) begin
      occ0 <= 0;
      occ1 <= 0;
    end else begin
      if (s_valid && s_ready) acc_q.push_back('{d: s_data, t: s_tag});
      if (m_valid && m_ready) got_q.push_back('{d: m_data, t: m_tag});
      occ0 <= occ0 + int'(s_valid && s_ready) - int'(m_valid && m_ready);
      occ1 <= occ1 + int'(s_valid1 && s_ready1) - int'(m_valid1 && m_ready1);
      if (occ0 > OUT_DEPTH) begin
        $display("FAIL credit_overflow: outstanding=%0d limit=%0d", occ0, OUT_DEPTH);
        failures = failures + 1;
      end
      if (occ1 > 1) begin
        $display("FAIL credit_overflow_d1: outstanding=%0d limit=1", occ1);
        failures = failures + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    rst = 1'b1;
    s_valid = 0; m_ready = 0; drain_req = 0; resume = 0; s_data = '0; s_tag = '0;
    s_valid1 = 0; m_ready1 = 0; drain_req1 = 0; resume1 = 0; s_data1 = '0; s_tag1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    acc_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    reset_dut();
    checks += 6;
    if (s_ready !== 1'b1) begin $display("FAIL reset_s_ready: got %b want 1", s_ready); failures++; end
    if (m_valid !== 1'b0) begin $display("FAIL reset_m_valid: got %b want 0", m_valid); failures++; end
    if (halted !== 1'b0) begin $display("FAIL reset_halted: got %b want 0", halted); failures++; end
    if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); failures++; end
    if ({m_data, m_tag} !== '0) begin $display("FAIL reset_m_out: got %h want 0", {m_data, m_tag}); failures++; end
    if (jobs_done !== '0) begin $display("FAIL reset_jobs_done: got %0d want 0", jobs_done); failures++; end
  endtask

  task automatic test_single();
    int lst[8] = '{7, 3, 0, 5, 1, 6, 2, 4};
    logic [N*K-1:0] v, exp_v;
    int lat;
    reset_dut();
    for (int i = 0; i < N; i++) begin
      v[i*K +: K] = K'(lst[i]);
      exp_v[i*K +: K] = K'(i);
    end
    m_ready = 1; s_valid = 1; s_data = v; s_tag = 4'd3;
    #1;
    checks++;
    if (srt_in !== v) begin $display("FAIL single_srt_in: got %h want %h", srt_in, v); failures++; end
    @(posedge clk); #1 s_valid = 0; s_data = '0;
    #1;
    checks++;
    if (srt_in !== '0) begin $display("FAIL single_srt_idle: got %h want 0", srt_in); failures++; end
    lat = -1;
    for (int c = 1; c <= SORT_LAT + 4 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (m_valid) lat = c;
    end
    checks += 3;
    if (lat != SORT_LAT) begin $display("FAIL single_latency: got %0d edges want %0d", lat, SORT_LAT); failures++; end
    if (m_data !== exp_v) begin $display("FAIL single_data: got %h want %h", m_data, exp_v); failures++; end
    if (m_tag !== 4'd3) begin $display("FAIL single_tag: got %0d want 3", m_tag); failures++; end
    @(posedge clk); #1;
    checks += 2;
    if (jobs_done !== 16'd1) begin $display("FAIL single_jobs_done: got %0d want 1", jobs_done); failures++; end
    if (m_valid !== 1'b0) begin $display("FAIL single_m_valid_after: got %b want 0", m_valid); failures++; end
  endtask

  task automatic test_back_to_back();
    int sent = 0, drops = 0, cyc = 0;
    item_t e;
    reset_dut();
    m_ready = 1;
    while (sent < 100 && cyc < 300) begin
      s_valid = 1; s_data = rand_vec(); s_tag = TAG_W'(sent);
      @(negedge clk);
      if (!s_ready) drops++; else sent++;
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 0;
    for (int c = 0; c < 60 && got_q.size() < 100; c++) begin @(posedge clk); #1; end
    checks += 2;
    if (drops != 0) begin $display("FAIL b2b_s_ready_drop: got %0d drops want 0", drops); failures++; end
    if (got_q.size() != 100 || acc_q.size() != 100) begin
      $display("FAIL b2b_count: got %0d results %0d accepts want 100", got_q.size(), acc_q.size()); failures++;
    end else begin
      for (int i = 0; i < 100; i++) begin
        e.d = sort_vec(acc_q[i].d); e.t = acc_q[i].t;
        checks += 2;
        if (got_q[i].t !== TAG_W'(i % 16)) begin $display("FAIL b2b_tag[%0d]: got %0d want %0d", i, got_q[i].t, i % 16); failures++; end
        if (got_q[i] !== e) begin $display("FAIL b2b_item[%0d]: got %h want %h", i, got_q[i], e); failures++; end
      end
    end
    checks++;
    if (jobs_done !== 16'd100) begin $display("FAIL b2b_jobs_done: got %0d want 100", jobs_done); failures++; end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    logic [N*K+TAG_W-1:0] snap;
    item_t e;
    reset_dut();
    m_ready = 0;
    for (int c = 0; c < 40; c++) begin
      s_valid = 1; s_data = rand_vec(); s_tag = TAG_W'(c);
      @(negedge clk);
      if (s_ready) acc++;
      @(posedge clk); #1;
    end
    checks += 2;
    if (acc != OUT_DEPTH) begin $display("FAIL bp_accepts: got %0d want %0d", acc, OUT_DEPTH); failures++; end
    if (s_ready !== 1'b0) begin $display("FAIL bp_s_ready: got %b want 0", s_ready); failures++; end
    s_valid = 0;
    snap = {m_data, m_tag};
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!m_valid || {m_data, m_tag} !== snap) begin
      $display("FAIL bp_hold: got v=%b %h want v=1 %h", m_valid, {m_data, m_tag}, snap); failures++;
    end
    m_ready = 1;
    for (int c = 0; c < 40 && got_q.size() < OUT_DEPTH; c++) begin @(posedge clk); #1; end
    checks++;
    if (got_q.size() != OUT_DEPTH || acc_q.size() != OUT_DEPTH) begin
      $display("FAIL bp_count: got %0d results %0d accepts want %0d", got_q.size(), acc_q.size(), OUT_DEPTH); failures++;
    end else begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        e.d = sort_vec(acc_q[i].d); e.t = acc_q[i].t;
        checks++;
        if (got_q[i] !== e) begin $display("FAIL bp_item[%0d]: got %h want %h", i, got_q[i], e); failures++; end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1) begin $display("FAIL bp_recover: got %b want 1", s_ready); failures++; end
  endtask

  task automatic test_drain();
    int viol = 0, bad_halt = 0;
    item_t e;
    reset_dut();
    m_ready = 1;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1; s_data = rand_vec(); s_tag = TAG_W'(i + 5);
      @(posedge clk); #1;
    end
    s_valid = 0; drain_req = 1;
    @(posedge clk); #1;
    drain_req = 0; s_valid = 1; s_data = rand_vec();
    checks++;
    if (s_ready !== 1'b0) begin $display("FAIL drain_s_ready: got %b want 0", s_ready); failures++; end
    for (int c = 0; c < 40 && !halted; c++) begin
      @(posedge clk); #1;
      if (s_ready) viol++;
      if (halted && busy) bad_halt++;
    end
    s_valid = 0;
    checks += 5;
    if (halted !== 1'b1) begin $display("FAIL drain_halted: got %b want 1", halted); failures++; end
    if (busy !== 1'b0 || bad_halt != 0) begin $display("FAIL drain_busy: got busy=%b bad=%0d want 0", busy, bad_halt); failures++; end
    if (viol != 0) begin $display("FAIL drain_ready_viol: got %0d want 0", viol); failures++; end
    if (acc_q.size() != 5) begin $display("FAIL drain_accepts: got %0d want 5", acc_q.size()); failures++; end
    if (got_q.size() != 5) begin $display("FAIL drain_results: got %0d want 5", got_q.size()); failures++; end
    for (int i = 0; i < 5 && i < got_q.size() && i < acc_q.size(); i++) begin
      e.d = sort_vec(acc_q[i].d); e.t = TAG_W'(i + 5);
      checks++;
      if (got_q[i] !== e) begin $display("FAIL drain_item[%0d]: got %h want %h", i, got_q[i], e); failures++; end
    end
    drain_req = 1; resume = 1;
    @(posedge clk); #1;
    drain_req = 0; resume = 0;
    checks++;
    if (halted !== 1'b1 || s_ready !== 1'b0) begin
      $display("FAIL drain_priority: got halted=%b s_ready=%b want 1 0", halted, s_ready); failures++;
    end
    resume = 1;
    @(posedge clk); #1;
    resume = 0;
    checks++;
    if (s_ready !== 1'b1 || halted !== 1'b0) begin
      $display("FAIL drain_resume: got s_ready=%b halted=%b want 1 0", s_ready, halted); failures++;
    end
  endtask

  task automatic test_reset_midflight();
    int mv = 0;
    reset_dut();
    m_ready = 1;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1; s_data = rand_vec(); s_tag = TAG_W'(i);
      @(posedge clk); #1;
    end
    s_valid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    for (int c = 0; c < 2 * SORT_LAT; c++) begin
      @(posedge clk); #1;
      if (m_valid) mv++;
    end
    checks += 3;
    if (mv != 0) begin $display("FAIL rstmid_m_valid: got %0d cycles want 0", mv); failures++; end
    if (busy !== 1'b0) begin $display("FAIL rstmid_busy: got %b want 0", busy); failures++; end
    if (jobs_done !== '0) begin $display("FAIL rstmid_jobs_done: got %0d want 0", jobs_done); failures++; end
  endtask

  task automatic test_random();
    item_t e;
    int bad = 0;
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data = rand_vec(); s_tag = TAG_W'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    s_valid = 0; m_ready = 1;
    for (int c = 0; c < 60 && busy; c++) begin @(posedge clk); #1; end
    checks += 2;
    if (got_q.size() != acc_q.size() || acc_q.size() < 50) begin
      $display("FAIL rand_count: got %0d results %0d accepts", got_q.size(), acc_q.size()); failures++;
    end else begin
      for (int i = 0; i < acc_q.size(); i++) begin
        e.d = sort_vec(acc_q[i].d); e.t = acc_q[i].t;
        if (got_q[i] !== e) begin
          bad++;
          $display("FAIL rand_item[%0d]: got %h want %h", i, got_q[i], e);
        end
      end
      if (bad != 0) failures++;
    end
    if (jobs_done !== CNT_W'(acc_q.size())) begin
      $display("FAIL rand_jobs_done: got %0d want %0d", jobs_done, acc_q.size()); failures++;
    end
  endtask

  task automatic test_depth1();
    item_t q[$];
    item_t e;
    int nacc = 0, npop = 0, last = 0, bad_int = 0, bad_data = 0;
    reset_dut();
    m_ready1 = 1;
    for (int cyc = 0; cyc < 270; cyc++) begin
      s_valid1 = (cyc < 250); s_data1 = rand_vec(); s_tag1 = TAG_W'($urandom);
      @(negedge clk);
      if (m_valid1 && m_ready1) begin
        if (q.size() == 0) bad_data++;
        else begin
          e = q.pop_front();
          if ({m_data1, m_tag1} !== e) bad_data++;
        end
        npop++;
      end
      if (s_valid1 && s_ready1) begin
        q.push_back('{d: sort_vec(s_data1), t: s_tag1});
        if (nacc > 0 && (cyc - last) != SORT_LAT + 2) bad_int++;
        last = cyc;
        nacc++;
      end
      @(posedge clk); #1;
    end
    checks += 5;
    if (nacc < 20) begin $display("FAIL d1_accepts: got %0d want >=20", nacc); failures++; end
    if (bad_int != 0) begin $display("FAIL d1_interval: got %0d bad gaps want 0", bad_int); failures++; end
    if (bad_data != 0) begin $display("FAIL d1_data: got %0d bad results want 0", bad_data); failures++; end
    if (npop != nacc || q.size() != 0) begin $display("FAIL d1_pops: got %0d want %0d", npop, nacc); failures++; end
    if (jobs_done1 !== CNT_W1'(npop)) begin $display("FAIL d1_jobs_done_wrap: got %0d want %0d", jobs_done1, CNT_W1'(npop)); failures++; end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_drain();
    test_reset_midflight();
    test_random();
    test_depth1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
